// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM states, default width and counter sizing for serial_adder.
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int SERIAL_ADDER_WIDTH_DEFAULT = 8;
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/FullAdder.sv
// FullAdder: the lab's one-bit full-adder cell, used as the bit-slice of serial_adder.
module FullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, through one FullAdder with a carry loop.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             Cout,
    output logic             Ovf
`else
    output logic             Cout
`endif
);
    localparam int CW = cnt_width(WIDTH);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a_sr, r_b_sr, r_sum_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             w_s, w_cout, w_accept, w_last;

    FullAdder u_fa (
        .A    (r_a_sr[0]),
        .B    (r_b_sr[0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    assign w_accept = Start && (r_state != SHIFT);
    assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
    assign Busy     = (r_state == SHIFT);
    assign Done     = (r_state == DONE);

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)
            w_state_nxt = SHIFT;
        else if (w_last)
            w_state_nxt = DONE;
        else if (r_state == DONE)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            Sum      <= '0;
            Cout     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf      <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a_sr  <= A;
                r_b_sr  <= B;
                r_carry <= Cin;
                r_cnt   <= '0;
            end else if (r_state == SHIFT) begin
                r_a_sr   <= r_a_sr >> 1;
                r_b_sr   <= r_b_sr >> 1;
                r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
                r_carry  <= w_cout;
                r_cnt    <= r_cnt + 1'b1;
            end
            // Outputs only update on completion so partial sums never leak out
            if (w_last) begin
                Sum  <= {w_s, r_sum_sr[WIDTH-1:1]};
                Cout <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
                Ovf  <= r_carry ^ w_cout;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven and scoreboard-checked bench for serial_adder (WIDTH=8).
module tb_serial_adder;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic         ovf;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    serial_adder #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Rst   (rst),
        .Start (start),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .Busy  (busy),
        .Done  (done),
        .Sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .Cout  (cout),
        .Ovf   (ovf)
`else
        .Cout  (cout)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.o));
`endif
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input exp_t e);
        start = 1'b1; a = xa; b = xb; cin = xc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_op(input vec_t v);
        int n;
        exp_t e;
        e = '{s: v.s, c: v.c, o: v.o};
        launch(v.a, v.b, v.cin, e);
        chk("busy_start", 32'(busy), 32'd1);
        wait_done(n);
        chk("latency", 32'(n), 32'(W));
        chk("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
    endtask

    function automatic vec_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        vec_t v;
        logic [W:0] t;
        t = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
        v.a = xa; v.b = xb; v.cin = xc;
        v.s = t[W-1:0];
        v.c = t[W];
        v.o = (xa[W-1] == xb[W-1]) && (t[W-1] != xa[W-1]);
        return v;
    endfunction

    initial begin
        vec_t tbl[6];
        int n;
        exp_t e;
        tbl[0] = '{a: 8'h3C, b: 8'h5A, cin: 1'b0, s: 8'h96, c: 1'b0, o: 1'b1};
        tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1, o: 1'b0};
        tbl[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, c: 1'b0, o: 1'b1};
        tbl[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, c: 1'b0, o: 1'b0};
        tbl[4] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, s: 8'h00, c: 1'b1, o: 1'b0};
        tbl[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, c: 1'b1, o: 1'b1};

        // Reset held two cycles with Start toggling
        for (int i = 0; i < 2; i++) begin
            start = (i == 0); a = 8'h12; b = 8'h34;
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_cout", 32'(cout), 32'd0);
            chk("rst_ovf", 32'(ovf), 32'd0);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) do_op(tbl[i]);
        for (int i = 0; i < 4; i++) do_op(model(W'($urandom), W'($urandom), 1'($urandom)));

        // Start during SHIFT must be ignored
        launch(8'hFF, 8'hFF, 1'b1, '{s: 8'hFF, c: 1'b1, o: 1'b0});
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h00; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ignored_start_latency", 32'(n), 32'd4);
        @(negedge clk);
        chk("ignored_start_idle", 32'(busy), 32'd0);

        // Back-to-back with Start held high through DONE
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        sb.push_back('{s: 8'h30, c: 1'b0, o: 1'b0});
        @(negedge clk);
        wait_done(n);
        chk("b2b_first_latency", 32'(n), 32'(W));
        a = 8'h01; b = 8'h02;
        sb.push_back('{s: 8'h03, c: 1'b0, o: 1'b0});
        @(negedge clk);
        start = 1'b0;
        chk("b2b_rearm_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("b2b_done_spacing", 32'(n + 1), 32'(W + 1));
        @(negedge clk);

        // Reset mid-SHIFT aborts with no Done and clears outputs
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        repeat (W) @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        e = '{s: 8'h0B, c: 1'b0, o: 1'b0};
        do_op('{a: 8'h05, b: 8'h06, cin: 1'b0, s: e.s, c: e.c, o: e.o});

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
